// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one request at a time to a combinational alu and queues the results.
//   clk, reset               : single clock; synchronous active-high reset
//   req_valid/ready/command/a/b                : request handshake and operands
//   alu_enable/command/a/b, alu_result/overflow: alu drive (registered) and alu return
//   rsp_valid/ready/result/overflow/error      : result FIFO head handshake
//   op_count/ovf_count/err_count               : saturating statistics
module alu_sequencer #(
  parameter int SIZE  = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_command,
  input  logic [SIZE-1:0]   req_a,
  input  logic [SIZE-1:0]   req_b,
  output logic              alu_enable,
  output logic [3:0]        alu_command,
  output logic [SIZE-1:0]   alu_a,
  output logic [SIZE-1:0]   alu_b,
  input  logic              alu_overflow,
  input  logic [2*SIZE-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*SIZE-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_error,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  err_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;
  logic [3:0] cmd_q, cmd_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [2*SIZE+1:0] mem_q [DEPTH];
  logic [2*SIZE+1:0] push_data, head;
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] op_q, ovf_q, err_q;
  logic accept, bad, push, pop;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction
  assign req_ready = (state_q == IDLE) && (cnt_q < FULL);
  assign accept = req_valid && req_ready;
  assign bad = req_command > 4'd9;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    a_d = a_q;
    b_d = b_q;
    push = 1'b0;
    if (state_q == EXEC) begin
      state_d = IDLE;
      push = 1'b1;
    end else if (accept && !bad) begin
      state_d = EXEC;
      cmd_d = req_command;
      a_d = req_a;
      b_d = req_b;
    end else if (accept) begin
      push = 1'b1;
    end
  end
  // invalid commands never reach the alu; they enqueue a zero result flagged as error
  assign push_data = (state_q == EXEC) ? {alu_result, alu_overflow, 1'b0} : {(2*SIZE+1)'(0), 1'b1};
  assign pop = rsp_valid && rsp_ready;
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign head = mem_q[rd_q];
  assign rsp_valid = cnt_q != '0;
  assign {rsp_result, rsp_overflow, rsp_error} = rsp_valid ? head : '0;
  assign alu_enable = state_q == EXEC;
  assign alu_command = cmd_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign op_count = op_q;
  assign ovf_count = ovf_q;
  assign err_count = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      a_q <= '0;
      b_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      ovf_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      a_q <= a_d;
      b_q <= b_d;
      wr_q <= push ? wr_q + PW'(1) : wr_q;
      rd_q <= pop ? rd_q + PW'(1) : rd_q;
      cnt_q <= cnt_d;
      op_q <= sat_inc(op_q, state_q == EXEC);
      ovf_q <= sat_inc(ovf_q, state_q == EXEC && alu_overflow);
      err_q <= sat_inc(err_q, accept && bad);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench for alu_sequencer with a behavioural alu and reference model.
module tb_alu_sequencer;
  localparam int SIZE = 2;
  localparam int DEPTH = 2;
  localparam int CNT_W = 3;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [3:0] req_command = 0, alu_command;
  logic [SIZE-1:0] req_a = 0, req_b = 0, alu_a, alu_b;
  logic alu_enable, alu_overflow, rsp_overflow, rsp_error;
  logic [2*SIZE-1:0] alu_result, rsp_result;
  logic [CNT_W-1:0] op_count, ovf_count, err_count;
  logic [3:0] noise = 0;
  logic [4:0] alu_out;
  always #5 clk = ~clk;
  alu_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command), .req_a(req_a), .req_b(req_b),
    .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
    .alu_overflow(alu_overflow), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error), .op_count(op_count), .ovf_count(ovf_count), .err_count(err_count)
  );
  function automatic logic [4:0] alu_f(input logic [3:0] c, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] r;
    if (c == 4'd4) r = 4'(a) + 4'(b);
    else if (c == 4'd8) r = 4'(a) * 4'(b);
    else r = {a, b} ^ c;
    return {r, (c == 4'd4 || c == 4'd8) ? (r > 4'd3) : ^{c, a, b}};
  endfunction
  always @(posedge clk) noise <= 4'($urandom);
  assign alu_out = alu_f(alu_command, alu_a, alu_b);
  assign alu_result = alu_enable ? alu_out[4:1] : noise;
  assign alu_overflow = alu_enable ? alu_out[0] : noise[0];
  logic [5:0] sb [$];
  int n_chk = 0, n_fail = 0;
  int occ = 0, op_m = 0, ovf_m = 0, err_m = 0;
  bit in_exec = 0, acc_flag = 0;
  logic [3:0] lc = 0;
  logic [1:0] la = 0, lb = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    bit push, pop, nx, rdy;
    logic [4:0] r;
    @(negedge clk);
    #1;
    acc_flag = 0;
    if (reset) begin
      sb.delete();
      occ = 0; in_exec = 0; op_m = 0; ovf_m = 0; err_m = 0;
    end else begin
      rdy = !in_exec && occ < DEPTH;
      chk("req_ready", req_ready, rdy);
      chk("rsp_valid", rsp_valid, occ != 0);
      chk("alu_enable", alu_enable, in_exec);
      if (in_exec) chk("alu_operands", {alu_command, alu_a, alu_b}, {lc, la, lb});
      chk("op_count", op_count, op_m);
      chk("ovf_count", ovf_count, ovf_m);
      chk("err_count", err_count, err_m);
      push = 0; nx = 0;
      if (in_exec) begin
        push = 1;
        r = alu_f(lc, la, lb);
        if (op_m < MAXC) op_m++;
        if (r[0] && ovf_m < MAXC) ovf_m++;
      end
      if (req_valid && rdy) begin
        acc_flag = 1;
        if (req_command < 4'd10) begin
          nx = 1; lc = req_command; la = req_a; lb = req_b;
          sb.push_back({alu_f(req_command, req_a, req_b), 1'b0});
        end else begin
          push = 1;
          if (err_m < MAXC) err_m++;
          sb.push_back(6'b000001);
        end
      end
      pop = occ != 0 && rsp_ready;
      occ = occ + int'(push) - int'(pop);
      in_exec = nx;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic issue(input logic [3:0] c, input logic [1:0] a, input logic [1:0] b);
    req_valid = 1; req_command = c; req_a = a; req_b = b;
    for (int i = 0; i < 50; i++) begin
      if (i > 5) rsp_ready = 1;
      cyc();
      if (acc_flag) break;
    end
    if (!acc_flag) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got no accept expected accept of cmd %0d", c);
    end
    req_valid = 0;
  endtask
  initial begin
    logic [5:0] held;
    bit held_v;
    held_v = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (reset) held_v = 0;
      else begin
        if (held_v) chk("rsp_stable", {rsp_valid, rsp_result, rsp_overflow, rsp_error}, {1'b1, held});
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_unexpected: got %0h expected no response", {rsp_result, rsp_overflow, rsp_error});
          end else chk("rsp_data", {rsp_result, rsp_overflow, rsp_error}, sb.pop_front());
        end
        held_v = rsp_valid && !rsp_ready;
        held = {rsp_result, rsp_overflow, rsp_error};
      end
    end
  end
  initial begin
    idle(2);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_overflow, rsp_error}, 0);
    chk("rst_alu", {alu_enable, alu_command, alu_a, alu_b}, 0);
    chk("rst_counters", {op_count, ovf_count, err_count}, 0);
    reset = 0;
    rsp_ready = 1;
    issue(4'd4, 2'b11, 2'b01);
    idle(3);
    chk("add_op_count", op_count, 1);
    chk("add_ovf_count", ovf_count, 1);
    issue(4'd8, 2'd3, 2'd3);
    idle(3);
    issue(4'd12, 2'd1, 2'd2);
    idle(2);
    chk("inv_err_count", err_count, 1);
    chk("inv_op_count", op_count, 2);
    rsp_ready = 0;
    issue(4'd1, 2'd1, 2'd2);
    issue(4'd2, 2'd2, 2'd3);
    req_valid = 1; req_command = 4'd3; req_a = 2'd3; req_b = 2'd0;
    idle(4);
    rsp_ready = 1;
    issue(4'd3, 2'd3, 2'd0);
    idle(4);
    issue(4'd9, 2'd2, 2'd2);
    reset = 1;
    cyc();
    reset = 0;
    idle(3);
    chk("rst_mid_exec_op", op_count, 0);
    for (int k = 0; k < 200; k++) begin
      rsp_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) != 0) issue(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom));
      else idle(1);
    end
    rsp_ready = 1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    idle(2);
    chk("drain_empty", sb.size(), 0);
    chk("op_saturated", op_count, MAXC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequential front-end that issues operations into the combinational alu block and collects their results.
- Accepts one operation request at a time over a valid/ready handshake and latches the operands.
- Drives the alu enable/command/a/b inputs for exactly one cycle, then captures result/overflow into a small result FIFO drained over a second valid/ready handshake.
- Keeps saturating statistics counters.

Parameters:
- SIZE, 2, operand width; alu result width is 2*SIZE.
- DEPTH, 2, result FIFO entries (power of two, >= 2).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_command  input  4  alu command code.
- req_a  input  SIZE  operand a.
- req_b  input  SIZE  operand b.
- alu_enable  output  1  to alu enable.
- alu_command  output  4  to alu command.
- alu_a  output  SIZE  to alu a.
- alu_b  output  SIZE  to alu b.
- alu_overflow  input  1  from alu overflow.
- alu_result  input  2*SIZE  from alu result.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer takes head.
- rsp_result  output  2*SIZE  head result.
- rsp_overflow  output  1  head overflow flag.
- rsp_error  output  1  head command was invalid.
- op_count  output  CNT_W  completed operations, saturating.
- ovf_count  output  CNT_W  completed operations with overflow=1, saturating.
- err_count  output  CNT_W  invalid commands, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE; FIFO empty; rsp_valid=0; rsp_result=0; rsp_overflow=0; rsp_error=0; alu_enable=0; alu_command=0; alu_a=0; alu_b=0; all counters=0.
- Reset mid-operation discards the latched operation and all FIFO contents. No response is produced for it.
- Valid commands are 0..9. Commands 10..15 are invalid.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - req_ready = (FIFO count < DEPTH).
  - On req_valid && req_ready with a valid command: latch command/a/b into the operand registers; next state is EXEC.
  - On an accepted invalid command: push {result=0, overflow=0, error=1} into the FIFO the same edge; increment err_count; stay in IDLE; the alu is not enabled.
- EXEC:
  - req_ready=0.
  - alu_enable=1 and alu_command/alu_a/alu_b = latched operands, all registered, for exactly this one cycle.
  - At the end of the cycle: push {alu_result, alu_overflow, error=0}; increment op_count; increment ovf_count if alu_overflow=1; next state is IDLE.
  - Outside EXEC, alu_enable=0 and the alu operand outputs hold their last values.
- Timing:
  - Latency: request accepted at edge N -> EXEC during cycle N+1 -> rsp_valid=1 after edge N+2 if the FIFO was empty.
  - Invalid-command response is visible after edge N+1.
  - Throughput is one valid operation per 2 cycles.
- FIFO:
  - Pop on rsp_valid && rsp_ready. rsp_* show the head entry; they are registered or head-indexed, never combinational from req_*.
  - Simultaneous push and pop in one cycle are both performed; count is unchanged.
  - A pop in the same cycle as an IDLE accept does not raise req_ready in that cycle. req_ready depends only on the registered count.
  - The accept rule guarantees a slot exists at the EXEC push. Pushing into a full FIFO must never occur; the bench asserts on it.
  - rsp_* hold steady while rsp_valid=1 && rsp_ready=0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Width rules:
  - alu_result is captured in full (2*SIZE bits) with no truncation.
  - Operands pass unmodified; no sign or zero extension happens in this block.

Test Plan:
- Reset then idle -> after reset: req_ready=1, rsp_valid=0, alu_enable=0, counters 0. Assert reset mid-EXEC -> next cycle IDLE, FIFO empty, no response appears.
- SIZE=2, command 4 (unsigned add), a=2'b11, b=2'b01, rsp_ready=1 -> alu_enable high exactly one cycle with command 4; rsp_valid 2 cycles after accept; rsp_result and rsp_overflow match the alu outputs (overflow=1); op_count=1, ovf_count=1.
- Command 8 (unsigned multiply), a=3, b=3 -> rsp_result=4'b1001, rsp_overflow=alu value, rsp_error=0.
- Command 12 -> alu_enable stays 0; response {0,0,error=1} one cycle after accept; err_count=1; op_count unchanged.
- rsp_ready=0, issue three valid ops with DEPTH=2 -> req_ready drops after the second push; the third is held until one pop; responses come out in order with stable rsp_* while stalled.
- Force op_count to 16'hFFFF (or use CNT_W=2 with 5 operations) -> counter holds its maximum value and does not wrap.
